// File: rtl/lru_set_controller_if.sv
// rtl/lru_set_controller_if.sv - access and response channels of the LRU set controller
interface lru_set_controller_if #(
  parameter int SET_W = 3
);
  logic [1:0]       acc_valid;
  logic [1:0]       acc_ready;
  logic [SET_W-1:0] acc_set0;
  logic [SET_W-1:0] acc_set1;
  logic [1:0]       acc_hit;
  logic [1:0]       acc_hit_way;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic             resp_way;

  modport master (
    output acc_valid, acc_set0, acc_set1, acc_hit, acc_hit_way, resp_ready,
    input  acc_ready, resp_valid, resp_id, resp_way
  );

  modport slave (
    input  acc_valid, acc_set0, acc_set1, acc_hit, acc_hit_way, resp_ready,
    output acc_ready, resp_valid, resp_id, resp_way
  );
endinterface

// File: rtl/lru_set_controller.sv
// rtl/lru_set_controller.sv - per-set 2-bit LRU table with two-requester round-robin access and flush
module lru_set_controller #(
  parameter int SET_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lru_set_controller_if.slave  bus,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 err_lru
);
  localparam int NUM_SETS = 1 << SET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic                       rr_last_q, rr_last_d;
  logic                       id_q, id_d;
  logic [SET_W-1:0]           set_q, set_d;
  logic                       hit_q, hit_d;
  logic                       hit_way_q, hit_way_d;
  logic                       first_q, first_d;
  logic [SET_W-1:0]           cnt_q, cnt_d;
  logic                       flush_done_q, flush_done_d;
  logic [NUM_SETS-1:0][1:0]   lru_q, lru_d;

  logic [1:0]                 grant;
  logic [1:0]                 lru_cur;
  logic                       way_sel;
  logic                       in_resp;

  // Bit i of an entry marks way i as MRU, so the victim is way1 only when way0 is MRU.
  assign lru_cur = lru_q[set_q];
  assign way_sel = hit_q ? hit_way_q : (lru_cur == 2'b01);
  assign in_resp = (state_q == RESP);

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    id_d         = id_q;
    set_d        = set_q;
    hit_d        = hit_q;
    hit_way_d    = hit_way_q;
    first_d      = first_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    lru_d        = lru_q;
    grant        = 2'b00;

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (bus.acc_valid != 2'b00) begin
          if (bus.acc_valid == 2'b11) begin
            grant = rr_last_q ? 2'b01 : 2'b10;
          end else begin
            grant = bus.acc_valid;
          end
          id_d      = grant[1];
          set_d     = grant[1] ? bus.acc_set1 : bus.acc_set0;
          hit_d     = bus.acc_hit[grant[1]];
          hit_way_d = bus.acc_hit_way[grant[1]];
          rr_last_d = grant[1];
          first_d   = 1'b1;
          state_d   = RESP;
        end
      end

      RESP: begin
        first_d = 1'b0;
        if (bus.resp_ready) begin
          lru_d[set_q] = way_sel ? 2'b10 : 2'b01;
          state_d      = IDLE;
        end
      end

      FLUSH: begin
        lru_d[cnt_q] = 2'b00;
        cnt_d        = cnt_q + 1'b1;
        if (&cnt_q) begin
          flush_done_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_last_q    <= 1'b1;
      id_q         <= 1'b0;
      set_q        <= '0;
      hit_q        <= 1'b0;
      hit_way_q    <= 1'b0;
      first_q      <= 1'b0;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      id_q         <= id_d;
      set_q        <= set_d;
      hit_q        <= hit_d;
      hit_way_q    <= hit_way_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      lru_q        <= lru_d;
    end
  end

  assign bus.acc_ready  = grant;
  assign bus.resp_valid = in_resp;
  assign bus.resp_id    = in_resp & id_q;
  assign bus.resp_way   = in_resp & way_sel;
  assign flush_busy     = (state_q == FLUSH);
  assign flush_done     = flush_done_q;
  // Illegal 11 is only reported on a miss, and only once per response.
  assign err_lru        = in_resp & first_q & ~hit_q & (lru_cur == 2'b11);
endmodule

// File: tb/tb_lru_set_controller.sv
// tb/tb_lru_set_controller.sv - scoreboard bench for the LRU set controller
module tb_lru_set_controller;
  logic clk;
  logic rst_n;
  logic flush_req;
  logic flush_busy;
  logic flush_done;
  logic err_lru;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;

  logic [1:0] exp_q[$];

  lru_set_controller_if #(.SET_W(3)) bus ();

  lru_set_controller #(.SET_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .err_lru    (err_lru)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every handshake.
  logic stall;
  logic hold_id;
  logic hold_way;
  logic [1:0] e;
  initial stall = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) check("acc_ready_during_resp", {30'd0, bus.acc_ready}, 32'd0);
      if (stall && bus.resp_valid) begin
        check("stable_resp_id", {31'd0, bus.resp_id}, {31'd0, hold_id});
        check("stable_resp_way", {31'd0, bus.resp_way}, {31'd0, hold_way});
      end
      if (err_lru) err_cnt++;
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got id %0d way %0d required none", bus.resp_id, bus.resp_way);
        end else begin
          e = exp_q.pop_front();
          check("resp_id", {31'd0, bus.resp_id}, {31'd0, e[1]});
          check("resp_way", {31'd0, bus.resp_way}, {31'd0, e[0]});
        end
      end
      stall    = bus.resp_valid && !bus.resp_ready;
      hold_id  = bus.resp_id;
      hold_way = bus.resp_way;
    end else begin
      stall = 1'b0;
    end
  end

  task automatic access(input logic id, input logic [2:0] set, input logic hit,
                        input logic hw, input logic exp_way);
    bit ok = 0;
    exp_q.push_back({id, exp_way});
    @(posedge clk); #1;
    if (id) begin
      bus.acc_set1 = set; bus.acc_hit[1] = hit; bus.acc_hit_way[1] = hw;
    end else begin
      bus.acc_set0 = set; bus.acc_hit[0] = hit; bus.acc_hit_way[0] = hw;
    end
    bus.acc_valid[id] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.acc_ready[id]) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: got no acc_ready required acc_ready[%0d]", id);
    end
    @(posedge clk); #1;
    bus.acc_valid[id] = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.resp_valid) begin ok = 1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got resp_valid stuck required idle");
    end
  endtask

  initial begin
    int g_idx;
    int cyc;
    int last_cyc;
    int busy_cnt;
    int done_cnt;
    bit seen_busy;
    logic [1:0] exp_g;

    rst_n = 1'b0;
    flush_req = 1'b0;
    bus.acc_valid = 2'b00;
    bus.acc_set0 = 3'd0;
    bus.acc_set1 = 3'd0;
    bus.acc_hit = 2'b00;
    bus.acc_hit_way = 2'b00;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_flush_busy", {31'd0, flush_busy}, 32'd0);
    check("rst_flush_done", {31'd0, flush_done}, 32'd0);
    check("rst_err_lru", {31'd0, err_lru}, 32'd0);
    check("rst_table", {16'd0, dut.lru_q}, 32'd0);
    rst_n = 1'b1;

    // Cold miss then repeat miss on set 3
    access(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    drain();
    check("t1_set3_after_miss1", {30'd0, dut.lru_q[3]}, 32'h1);
    access(1'b0, 3'd3, 1'b0, 1'b0, 1'b1);
    drain();
    check("t1_set3_after_miss2", {30'd0, dut.lru_q[3]}, 32'h2);

    // Hit updates then miss victim on set 5
    access(1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
    drain();
    check("t2_set5_hit_way1", {30'd0, dut.lru_q[5]}, 32'h2);
    access(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
    drain();
    check("t2_set5_hit_way0", {30'd0, dut.lru_q[5]}, 32'h1);
    access(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    drain();
    check("t2_set5_miss", {30'd0, dut.lru_q[5]}, 32'h2);

    // Both requesters held high: alternate grants, 2 cycles apart
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    @(posedge clk); #1;
    bus.acc_set0 = 3'd0; bus.acc_set1 = 3'd1;
    bus.acc_hit = 2'b00; bus.acc_hit_way = 2'b00;
    bus.acc_valid = 2'b11;
    g_idx = 0; cyc = 0; last_cyc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.acc_ready != 2'b00) begin
        exp_g = g_idx[0] ? 2'b10 : 2'b01;
        check("t3_grant", {30'd0, bus.acc_ready}, {30'd0, exp_g});
        if (g_idx > 0) check("t3_accept_spacing", cyc - last_cyc, 32'd2);
        last_cyc = cyc;
        g_idx++;
        if (g_idx == 4) break;
      end
    end
    check("t3_grant_count", g_idx, 32'd4);
    @(posedge clk); #1;
    bus.acc_valid = 2'b00;
    drain();
    check("t3_set0", {30'd0, dut.lru_q[0]}, 32'h2);
    check("t3_set1", {30'd0, dut.lru_q[1]}, 32'h2);

    // Back-pressure: response held, table untouched until handshake
    bus.resp_ready = 1'b0;
    access(1'b0, 3'd6, 1'b1, 1'b1, 1'b1);
    bus.acc_set1 = 3'd7; bus.acc_hit[1] = 1'b0; bus.acc_valid[1] = 1'b1;
    exp_q.push_back(2'b10);
    repeat (3) begin
      @(negedge clk);
      check("t4_resp_valid_held", {31'd0, bus.resp_valid}, 32'd1);
      check("t4_no_write_stall", {30'd0, dut.lru_q[6]}, 32'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("t4_no_write_before_edge", {30'd0, dut.lru_q[6]}, 32'd0);
    @(posedge clk); #1;
    check("t4_write_on_handshake", {30'd0, dut.lru_q[6]}, 32'h2);
    @(negedge clk);
    check("t4_pending_grant", {30'd0, bus.acc_ready}, 32'h2);
    @(posedge clk); #1;
    bus.acc_valid = 2'b00;
    drain();

    // Populate all sets, flush requested during a stalled response
    for (int i = 0; i < 7; i++) begin
      access(1'b0, 3'(i), 1'b1, i[0], i[0]);
    end
    drain();
    bus.resp_ready = 1'b0;
    access(1'b0, 3'd7, 1'b1, 1'b1, 1'b1);
    flush_req = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t5_flush_waits", {31'd0, flush_busy}, 32'd0);
    end
    for (int i = 0; i < 7; i++) begin
      check("t5_populated", {30'd0, dut.lru_q[i]}, i[0] ? 32'h2 : 32'h1);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    busy_cnt = 0; done_cnt = 0; seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (flush_busy) begin
        if (!seen_busy) check("t5_set7_written", {30'd0, dut.lru_q[7]}, 32'h2);
        seen_busy = 1;
        busy_cnt++;
      end
      if (flush_done) begin done_cnt++; break; end
      if (flush_req && flush_busy) begin @(posedge clk); #1; flush_req = 1'b0; end
    end
    check("t5_busy_cycles", busy_cnt, 32'd8);
    check("t5_done_seen", done_cnt, 32'd1);
    @(negedge clk);
    check("t5_done_one_cycle", {31'd0, flush_done}, 32'd0);
    check("t5_table_cleared", {16'd0, dut.lru_q}, 32'd0);

    // Reset in the middle of a flush
    access(1'b0, 3'd3, 1'b0, 1'b0, 1'b0);
    drain();
    check("t5_set3_before_flush", {30'd0, dut.lru_q[3]}, 32'h1);
    @(posedge clk); #1;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_midflush_busy", {31'd0, flush_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_table", {16'd0, dut.lru_q}, 32'd0);
    check("t5_rst_busy", {31'd0, flush_busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Illegal 11 state recovered by a miss
    check("t6_no_err_before", err_cnt, 32'd0);
    @(negedge clk);
    force dut.lru_q = 16'h0030;
    @(negedge clk);
    release dut.lru_q;
    bus.resp_ready = 1'b0;
    access(1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    drain();
    check("t6_err_single_pulse", err_cnt, 32'd1);
    check("t6_set2_recovered", {30'd0, dut.lru_q[2]}, 32'h1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
